// File: rtl/carry_save_adder_pipeline.sv
// Pipelined WIDTH-bit unsigned adder: one SEG-bit carry segment per stage,
// inter-segment carry and unconsumed operand bits registered between stages.
module carry_save_adder_pipeline #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum
);

  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0 || STAGES < 2) begin : g_param_check
    $error("carry_save_adder_pipeline: WIDTH must be a multiple of SEG with at least 2 segments");
  end

  // res holds the segments computed so far, skewed down the pipe
  logic [WIDTH-1:0] res_d   [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  // operand bits not yet consumed, right-aligned so the next segment is at [SEG-1:0]
  logic [WIDTH-1:0] a_d     [STAGES-1];
  logic [WIDTH-1:0] a_q     [STAGES-1];
  logic [WIDTH-1:0] b_d     [STAGES-1];
  logic [WIDTH-1:0] b_q     [STAGES-1];
  logic             carry_d [STAGES-1];
  logic             carry_q [STAGES-1];
  logic [SEG:0]     seg_sum [STAGES];

  always_comb begin
    seg_sum[0] = {1'b0, A[SEG-1:0]} + {1'b0, B[SEG-1:0]};
    res_d[0]   = '0;
    res_d[0][SEG-1:0] = seg_sum[0][SEG-1:0];
    carry_d[0] = seg_sum[0][SEG];
    a_d[0]     = A >> SEG;
    b_d[0]     = B >> SEG;

    for (int s = 1; s < STAGES; s++) begin
      seg_sum[s] = {1'b0, a_q[s-1][SEG-1:0]} + {1'b0, b_q[s-1][SEG-1:0]}
                 + {{SEG{1'b0}}, carry_q[s-1]};
      res_d[s] = res_q[s-1];
      res_d[s][s*SEG +: SEG] = seg_sum[s][SEG-1:0];
    end

    // the carry out of the top segment is dropped: results wrap mod 2^WIDTH
    for (int s = 1; s < STAGES-1; s++) begin
      carry_d[s] = seg_sum[s][SEG];
      a_d[s]     = a_q[s-1] >> SEG;
      b_d[s]     = b_q[s-1] >> SEG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        res_q[s] <= '0;
      end
      for (int s = 0; s < STAGES-1; s++) begin
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        carry_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        res_q[s] <= res_d[s];
      end
      for (int s = 0; s < STAGES-1; s++) begin
        a_q[s]     <= a_d[s];
        b_q[s]     <= b_d[s];
        carry_q[s] <= carry_d[s];
      end
    end
  end

  assign sum = res_q[STAGES-1];

endmodule

// File: tb/tb_carry_save_adder_pipeline.sv
// Directed self-checking bench for carry_save_adder_pipeline (default 32/8, latency 4).
module tb_carry_save_adder_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;

  int total = 0;
  int bad   = 0;

  carry_save_adder_pipeline #(.WIDTH(32), .SEG(8)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (a),
    .B     (b),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 6;
  localparam logic [31:0] VA [NV] = '{32'h00FF00FF, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                      32'hFFFFFFFF, 32'h000000FF, 32'h80000000};
  localparam logic [31:0] VB [NV] = '{32'h00010001, 32'h00000001, 32'h00000001,
                                      32'hFFFFFFFF, 32'h00000001, 32'h80000000};
  localparam logic [31:0] VE [NV] = '{32'h01000100, 32'h80000000, 32'h00000000,
                                      32'hFFFFFFFE, 32'h00000100, 32'h00000000};

  initial begin
    // reset held for 3 edges
    reset = 1'b1;
    a = 32'h12345678;
    b = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("reset_hold%0d", i), sum, 32'h0);
    end
    reset = 1'b0;

    // first non-reset edge k samples the operands; result after edge k+3
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("drain%0d", i), sum, 32'h0);
    end
    tick();
    check_eq("first_result", sum, 32'h23456789);

    // simple add: not visible before the 4th edge
    a = 32'd5;
    b = 32'd3;
    tick();
    tick();
    tick();
    check_eq("add_early", sum, 32'h23456789);
    tick();
    check_eq("add_5_3", sum, 32'h00000008);

    // cross-segment carries and wrap-around, issued back to back
    for (int i = 0; i < NV + 3; i++) begin
      if (i < NV) begin
        a = VA[i];
        b = VB[i];
      end
      tick();
      if (i >= 3) check_eq($sformatf("vec%0d", i - 3), sum, VE[i-3]);
    end

    // streaming: B increments every cycle, A every other cycle
    for (int i = 0; i < 20; i++) begin
      a = 32'(i / 2);
      b = 32'(i);
      tick();
      if (i >= 3) check_eq($sformatf("stream%0d", i - 3), sum, 32'((i - 3) / 2 + (i - 3)));
    end

    // reset mid-stream flushes everything in flight
    for (int i = 0; i < 4; i++) begin
      a = 32'h10000000 + 32'(i) * 32'h00000101;
      b = 32'h02000000;
      tick();
    end
    reset = 1'b1;
    a = 32'h0000DEAD;
    b = 32'h0000BEEF;
    tick();
    check_eq("flush_r0", sum, 32'h0);
    reset = 1'b0;
    a = 32'h0A0A0A0A;
    b = 32'h01010101;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq($sformatf("flush_r%0d", i), sum, 32'h0);
    end
    tick();
    check_eq("post_flush", sum, 32'h0B0B0B0B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
